uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among N_REQ independent requesters, such as a telemetry sender, a command echo and a status reporter.
- Arbitrates round-robin at packet granularity. A winning requester owns the UART until it marks a byte as last.
- Sequences the UART handshake: one-cycle transmit pulse, then waits for is_transmitting to rise and fall before the next byte.
- Sits between the requester logic and the uart module, in the same clock domain.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- ID_W, 3: width of grant_id; N_REQ <= 2**ID_W.
- START_TIMEOUT, 16: clocks allowed for uart_is_transmitting to rise after a launch.

Ports:
- clk  in  1  master clock.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester byte-valid; held high until the matching ack.
- req_byte  in  8*N_REQ  byte for requester i in bits [8i+7:8i]; stable while req[i] is high.
- req_last  in  N_REQ  qualifies req[i]: this byte ends the packet.
- ack  out  N_REQ  one-cycle pulse; byte of requester i handed to the UART.
- grant_id  out  ID_W  current owner index; valid while busy.
- busy  out  1  high from the first launch of a packet until its last byte completes.
- launch_error  out  1  one-cycle pulse; UART never started after a launch.
- uart_transmit  out  1  to uart.transmit.
- uart_tx_byte  out  8  to uart.tx_byte; registered.
- uart_is_transmitting  in  1  from uart.is_transmitting.

Behaviour:
- Reset values: ack=0, uart_transmit=0, uart_tx_byte=8'h00, busy=0, grant_id=0, launch_error=0, state=ARB_IDLE, rr_ptr=N_REQ-1. With rr_ptr=N_REQ-1, requester 0 has highest priority first.
- Reset mid-operation aborts the packet immediately. A byte already launched still finishes on the wire inside the uart. The arbiter sits in ARB_IDLE and starts ARB_WAIT_IDLE gating: it may not launch while uart_is_transmitting=1.
- Priority search: the winner is the first i with req[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
- ARB_IDLE:
  - Leave only if any req is high and uart_is_transmitting=0.
  - Latch the winner into grant_id, latch its byte into uart_tx_byte, set busy=1, go to ARB_LAUNCH.
  - Decision cycle t gives launch at t+1.
- ARB_LAUNCH (exactly 1 cycle):
  - uart_transmit=1 and ack[grant_id]=1 in the same cycle.
  - Latch req_last[grant_id] into last_q. Clear the timeout counter. Go to ARB_WAIT_START.
- ARB_WAIT_START:
  - uart_is_transmitting=1 goes to ARB_WAIT_DONE.
  - If the counter reaches START_TIMEOUT first: pulse launch_error, clear busy, set rr_ptr=grant_id, go to ARB_IDLE. The packet is dropped.
- ARB_WAIT_DONE: uart_is_transmitting=0 goes to ARB_NEXT.
- ARB_NEXT:
  - If last_q=1: busy=0, rr_ptr=grant_id, go to ARB_IDLE.
  - Else go to ARB_HOLD.
- ARB_HOLD:
  - Only the owner is considered; other requesters wait however long.
  - When req[grant_id]=1: latch its byte and go to ARB_LAUNCH.
  - req from any other requester is ignored.
- Ack and byte rules:
  - ack is never asserted for a requester other than grant_id.
  - At most one ack per UART byte.
  - A requester may drop req only after its ack. It may present its next byte in the cycle after ack.
- Simultaneous events:
  - Multiple reqs in ARB_IDLE: the rotating priority resolves them.
  - req_last=1 on a single-byte packet is legal (one launch, then release).
  - Owner deasserts req without last: the arbiter stays locked in ARB_HOLD until the owner sends more or rst.
- Throughput: at most one byte per UART frame, plus 3 clocks of arbiter overhead per byte.

Optional Feature:
- Macro UART_ARB_SRCID_EN.
- When defined, each packet is prefixed with a header byte {4'hA, 1'b0, grant_id padded/truncated to 3 bits}.
  - It is sent via an extra ARB_HDR launch before the first data byte.
  - No ack is issued for the header.
  - last_q is forced 0 for the header.
  - Timeout on the header drops the whole packet.
- When undefined, there is no header and no ARB_HDR state. Bytes go out verbatim.

Test Plan:
1. Single-byte packet: after reset, req[2]=1, byte 8'h5A, last=1.
   - Required: uart_transmit pulses 1 cycle later with uart_tx_byte=8'h5A and ack[2] in the same cycle.
   - After the bench UART model drops is_transmitting: busy=0 and rr_ptr=2.
2. Round-robin fairness: req[0], req[1] and req[3] all high continuously, each sending single-byte packets.
   - Required grant order: 0, 1, 3, 0, 1, 3.
   - No requester gets two consecutive packets while another is pending.
3. Packet lock: req[1] sends 3 bytes (11, 22, 33; last on 33) while req[0] is held high throughout.
   - Required: bytes go out in the order 11, 22, 33, then requester 0's byte.
   - ack[0] stays 0 until 33 completes.
4. Launch timeout: the bench holds uart_is_transmitting=0 after a launch.
   - Required: launch_error pulses exactly START_TIMEOUT=16 cycles after ARB_WAIT_START entry, busy=0, and the next requester is served.
5. Reset mid-byte: assert rst during ARB_WAIT_DONE while is_transmitting=1, with req[0] pending.
   - Required: no uart_transmit until is_transmitting falls.
   - Then requester 0 is granted first.
6. UART_ARB_SRCID_EN build: req[3] byte 8'h41 with last=1.
   - Required: wire bytes are 8'hA3 then 8'h41.
   - Exactly one ack[3] pulse, coincident with the 8'h41 launch.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the arbiter and the uart transmitter.
//
// Handshake: requester i raises req[i] with req_byte/req_last stable and
// keeps them until ack[i] pulses for one cycle. That ack marks the byte as
// handed to the uart. The requester may drop req, or present its next byte,
// from the cycle after the ack. uart_transmit is a one-cycle launch pulse,
// and uart_is_transmitting rising then falling marks the frame on the wire.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 3
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_byte;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   ack;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               launch_error;
  logic               uart_transmit;
  logic [7:0]         uart_tx_byte;
  logic               uart_is_transmitting;

  // Arbiter side.
  modport slave (
    input  req, req_byte, req_last, uart_is_transmitting,
    output ack, grant_id, busy, launch_error, uart_transmit, uart_tx_byte
  );

  // Requester/uart side.
  modport master (
    output req, req_byte, req_last, uart_is_transmitting,
    input  ack, grant_id, busy, launch_error, uart_transmit, uart_tx_byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart transmitter among N_REQ requesters.
// Arbitration is round-robin at packet granularity: a winner keeps the uart
// until a byte it sends carries req_last.
// Optional macro UART_ARB_SRCID_EN: prefix each packet with a header byte
// {4'hA, 1'b0, grant_id[2:0]}. The header is launched without an ack.
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int ID_W          = 3,
  parameter int START_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_arbiter_if.slave    bus,
  output logic [2:0]          dbg_state_o,
  output logic [ID_W-1:0]     dbg_rr_ptr_o
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  localparam logic [2:0] ARB_IDLE       = 3'd0;
  localparam logic [2:0] ARB_LAUNCH     = 3'd1;
  localparam logic [2:0] ARB_WAIT_START = 3'd2;
  localparam logic [2:0] ARB_WAIT_DONE  = 3'd3;
  localparam logic [2:0] ARB_NEXT       = 3'd4;
  localparam logic [2:0] ARB_HOLD       = 3'd5;
`ifdef UART_ARB_SRCID_EN
  localparam logic [2:0] ARB_HDR        = 3'd6;
`endif

  logic [2:0]       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]       byte_q, byte_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             xmit_q, xmit_d;
  logic             lerr_q, lerr_d;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  int               cand;
  logic             own_req;
  logic             own_last;
  logic [7:0]       own_byte;
  logic [N_REQ-1:0] own_oh;

  // Rotating priority search: first requester after rr_ptr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (i == cand && bus.req[i]) begin
          win_found = 1'b1;
          win_id    = ID_W'(i);
        end
      end
    end
  end

  // Signals of the current owner, selected by grant_q.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_byte = '0;
    own_oh   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grant_q) begin
        own_req   = bus.req[i];
        own_last  = bus.req_last[i];
        own_byte  = bus.req_byte[8*i +: 8];
        own_oh[i] = 1'b1;
      end
    end
  end

`ifdef UART_ARB_SRCID_EN
  logic [7:0] hdr_byte;
  // Header byte names the winner; ids wider than 3 bits are truncated.
  always_comb begin
    hdr_byte = {4'hA, 1'b0, 3'(win_id)};
  end
`else
  logic [7:0]       win_byte;
  logic [N_REQ-1:0] win_oh;
  // Byte and one-hot ack of the arbitration winner.
  always_comb begin
    win_byte = '0;
    win_oh   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == win_id) begin
        win_byte  = bus.req_byte[8*i +: 8];
        win_oh[i] = 1'b1;
      end
    end
  end
`endif

  // Next-state logic; the launch and ack pulses are registered outputs.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    byte_d   = byte_q;
    busy_d   = busy_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    xmit_d   = 1'b0;
    lerr_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // Never launch onto a uart still finishing an earlier frame.
        if (win_found && !bus.uart_is_transmitting) begin
          grant_d = win_id;
          busy_d  = 1'b1;
          xmit_d  = 1'b1;
`ifdef UART_ARB_SRCID_EN
          byte_d  = hdr_byte;
          state_d = ARB_HDR;
`else
          byte_d  = win_byte;
          ack_d   = win_oh;
          state_d = ARB_LAUNCH;
`endif
        end
      end
`ifdef UART_ARB_SRCID_EN
      ARB_HDR: begin
        last_d  = 1'b0;
        cnt_d   = '0;
        state_d = ARB_WAIT_START;
      end
`endif
      ARB_LAUNCH: begin
        last_d  = own_last;
        cnt_d   = '0;
        state_d = ARB_WAIT_START;
      end
      ARB_WAIT_START: begin
        if (bus.uart_is_transmitting) begin
          state_d = ARB_WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          // The uart never started; drop the rest of the packet.
          lerr_d   = 1'b1;
          busy_d   = 1'b0;
          rr_ptr_d = grant_q;
          state_d  = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_WAIT_DONE: begin
        if (!bus.uart_is_transmitting) state_d = ARB_NEXT;
      end
      ARB_NEXT: begin
        if (last_q) begin
          busy_d   = 1'b0;
          rr_ptr_d = grant_q;
          state_d  = ARB_IDLE;
        end else begin
          state_d = ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        // Packet lock: only the owner can continue, others wait.
        if (own_req) begin
          byte_d  = own_byte;
          ack_d   = own_oh;
          xmit_d  = 1'b1;
          state_d = ARB_LAUNCH;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= ID_W'(N_REQ - 1);
      byte_q   <= 8'h00;
      busy_q   <= 1'b0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= '0;
      xmit_q   <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      byte_q   <= byte_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      xmit_q   <= xmit_d;
      lerr_q   <= lerr_d;
    end
  end

  assign bus.ack           = ack_q;
  assign bus.grant_id      = grant_q;
  assign bus.busy          = busy_q;
  assign bus.launch_error  = lerr_q;
  assign bus.uart_transmit = xmit_q;
  assign bus.uart_tx_byte  = byte_q;
  assign dbg_state_o       = state_q;
  assign dbg_rr_ptr_o      = rr_ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a behavioural uart, and a
// packet-level round-robin reference model for the randomized scenario.
module tb_uart_tx_arbiter;

  localparam int N_REQ         = 4;
  localparam int ID_W          = 3;
  localparam int START_TIMEOUT = 16;
  localparam int DEPTH         = 128;
`ifdef UART_ARB_SRCID_EN
  localparam int HDR_EN = 1;
`else
  localparam int HDR_EN = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]      dbg_state;
  logic [ID_W-1:0] dbg_rr;
  int checks = 0;
  int errors = 0;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  uart_tx_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .START_TIMEOUT(START_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dbg_state_o  (dbg_state),
    .dbg_rr_ptr_o (dbg_rr)
  );

  // ---------------- requester driver ----------------
  logic [8:0] rq_mem [N_REQ][DEPTH];
  int rq_head [N_REQ] = '{default: 0};
  int rq_tail [N_REQ] = '{default: 0};
  int rise_cyc [N_REQ] = '{default: 0};

  task automatic push_byte(input int id, input logic last, input logic [7:0] b);
    rq_mem[id][rq_tail[id]] = {last, b};
    rq_tail[id] = rq_tail[id] + 1;
  endtask

  function automatic bit all_drained();
    for (int i = 0; i < N_REQ; i++) if (rq_head[i] != rq_tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] hdr_of(input int id);
    logic [2:0] id3;
    id3 = id[2:0];
    return {4'hA, 1'b0, id3};
  endfunction

  initial begin : requester_driver
    logic [N_REQ-1:0] acked;
    logic [8:0] v;
    bus.req = '0;
    bus.req_byte = '0;
    bus.req_last = '0;
    forever begin
      @(negedge clk);
      acked = bus.ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (acked[i] && rq_head[i] != rq_tail[i]) rq_head[i] = rq_head[i] + 1;
        if (rq_head[i] != rq_tail[i]) begin
          v = rq_mem[i][rq_head[i]];
          if (!bus.req[i]) rise_cyc[i] = cyc;
          bus.req[i] = 1'b1;
          bus.req_byte[8*i +: 8] = v[7:0];
          bus.req_last[i] = v[8];
        end else begin
          bus.req[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- behavioural uart ----------------
  bit uart_en     = 1'b1;
  bit rand_timing = 1'b0;
  int start_dly   = 2;
  int frame_len   = 6;

  initial begin : uart_model
    int d;
    int l;
    bus.uart_is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.uart_transmit && uart_en) begin
        d = rand_timing ? int'($urandom_range(1, 5)) : start_dly;
        l = rand_timing ? int'($urandom_range(2, 8)) : frame_len;
        repeat (d) @(negedge clk);
        bus.uart_is_transmitting = 1'b1;
        repeat (l) @(negedge clk);
        bus.uart_is_transmitting = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [7:0]       tx_bytes [$];
  logic [N_REQ-1:0] tx_acks [$];
  logic [ID_W-1:0]  tx_grants [$];
  int               tx_cycs [$];
  int               ack_ids [$];
  int               lerr_cycs [$];
  int               bad_acks = 0;

  always @(negedge clk) begin
    if (bus.uart_transmit) begin
      tx_bytes.push_back(bus.uart_tx_byte);
      tx_acks.push_back(bus.ack);
      tx_grants.push_back(bus.grant_id);
      tx_cycs.push_back(cyc);
    end
    if (bus.launch_error) lerr_cycs.push_back(cyc);
    if (bus.ack != '0) begin
      if (!bus.uart_transmit || bus.ack != (N_REQ'(1) << bus.grant_id)) bad_acks <= bad_acks + 1;
      for (int i = 0; i < N_REQ; i++) if (bus.ack[i]) ack_ids.push_back(i);
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q [$];
  int         exp_ack_q [$];

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (n < max_cyc && !(all_drained() && !bus.busy && !bus.uart_is_transmitting)) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.ack, bus.uart_transmit, bus.launch_error, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_pulses: ack=%b xmit=%b lerr=%b busy=%b, required all 0",
               bus.ack, bus.uart_transmit, bus.launch_error, bus.busy);
    end
    checks++;
    if (bus.uart_tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_byte: got %h required 00", bus.uart_tx_byte);
    end
    checks++;
    if (bus.grant_id !== '0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_grant_state: grant=%0d state=%0d required 0/0", bus.grant_id, dbg_state);
    end
    checks++;
    if (dbg_rr !== ID_W'(N_REQ - 1)) begin
      errors++;
      $display("FAIL reset_rr_ptr: got %0d required %0d", dbg_rr, N_REQ - 1);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_single_byte();
    int base;
    int n;
    apply_reset();
    @(negedge clk);
    base = tx_bytes.size();
    push_byte(2, 1'b1, 8'h5A);
    n = 0;
    while (tx_bytes.size() < base + 1 + HDR_EN && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (tx_bytes.size() < base + 1 + HDR_EN) begin
      errors++;
      $display("FAIL single_wait: %0d launches seen, required %0d", tx_bytes.size() - base, 1 + HDR_EN);
    end else begin
      checks++;
      if (tx_cycs[base] - rise_cyc[2] != 1) begin
        errors++;
        $display("FAIL single_latency: launch %0d cycles after req, required 1", tx_cycs[base] - rise_cyc[2]);
      end
      checks++;
      if (tx_bytes[base + HDR_EN] !== 8'h5A || tx_acks[base + HDR_EN] !== 4'b0100) begin
        errors++;
        $display("FAIL single_byte_ack: byte=%h ack=%b required 5a/0100",
                 tx_bytes[base + HDR_EN], tx_acks[base + HDR_EN]);
      end
      if (HDR_EN == 1) begin
        checks++;
        if (tx_bytes[base] !== hdr_of(2) || tx_acks[base] !== '0) begin
          errors++;
          $display("FAIL single_hdr: byte=%h ack=%b required %h/0000", tx_bytes[base], tx_acks[base], hdr_of(2));
        end
      end
    end
    wait_drain("single", 300);
    checks++;
    if (bus.busy !== 1'b0 || dbg_rr !== 3'd2) begin
      errors++;
      $display("FAIL single_release: busy=%b rr_ptr=%0d required 0/2", bus.busy, dbg_rr);
    end
  endtask

  task automatic test_round_robin();
    int base;
    int expect_ids [6] = '{0, 1, 3, 0, 1, 3};
    apply_reset();
    @(negedge clk);
    base = ack_ids.size();
    for (int p = 0; p < 2; p++) begin
      push_byte(0, 1'b1, 8'($urandom_range(0, 255)));
      push_byte(1, 1'b1, 8'($urandom_range(0, 255)));
      push_byte(3, 1'b1, 8'($urandom_range(0, 255)));
    end
    wait_drain("rr", 1000);
    checks++;
    if (ack_ids.size() - base != 6) begin
      errors++;
      $display("FAIL rr_count: %0d grants, required 6", ack_ids.size() - base);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (ack_ids[base + k] != expect_ids[k]) begin
          errors++;
          $display("FAIL rr_order[%0d]: granted %0d required %0d", k, ack_ids[base + k], expect_ids[k]);
        end
      end
    end
  endtask

  task automatic test_packet_lock();
    int base_a;
    int base_t;
    int n;
    logic [7:0] exp_b [$];
    int exp_a [4] = '{1, 1, 1, 0};
    apply_reset();
    @(negedge clk);
    base_a = ack_ids.size();
    base_t = tx_bytes.size();
    push_byte(1, 1'b0, 8'h11);
    push_byte(1, 1'b0, 8'h22);
    push_byte(1, 1'b1, 8'h33);
    n = 0;
    while (ack_ids.size() == base_a && n < 200) begin @(negedge clk); n++; end
    push_byte(0, 1'b1, 8'h44);
    wait_drain("lock", 1000);
    if (HDR_EN == 1) exp_b.push_back(hdr_of(1));
    exp_b.push_back(8'h11); exp_b.push_back(8'h22); exp_b.push_back(8'h33);
    if (HDR_EN == 1) exp_b.push_back(hdr_of(0));
    exp_b.push_back(8'h44);
    checks++;
    if (tx_bytes.size() - base_t != exp_b.size() || ack_ids.size() - base_a != 4) begin
      errors++;
      $display("FAIL lock_count: %0d bytes %0d acks, required %0d/4",
               tx_bytes.size() - base_t, ack_ids.size() - base_a, exp_b.size());
    end else begin
      foreach (exp_b[k]) begin
        checks++;
        if (tx_bytes[base_t + k] !== exp_b[k]) begin
          errors++;
          $display("FAIL lock_byte[%0d]: got %h required %h", k, tx_bytes[base_t + k], exp_b[k]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ack_ids[base_a + k] != exp_a[k]) begin
          errors++;
          $display("FAIL lock_ack[%0d]: got %0d required %0d", k, ack_ids[base_a + k], exp_a[k]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int base_t;
    int base_e;
    int n;
    int err_cyc;
    apply_reset();
    @(negedge clk);
    uart_en = 1'b0;
    base_t = tx_bytes.size();
    base_e = lerr_cycs.size();
    push_byte(1, 1'b1, 8'h77);
    push_byte(3, 1'b1, 8'h99);
    n = 0;
    while (!bus.launch_error && n < 200) begin @(negedge clk); n++; end
    err_cyc = cyc;
    uart_en = 1'b1;
    checks++;
    if (!bus.launch_error) begin
      errors++;
      $display("FAIL timeout_pulse: no launch_error within %0d cycles", n);
    end else begin
      checks++;
      if (err_cyc - tx_cycs[base_t] != START_TIMEOUT + 1) begin
        errors++;
        $display("FAIL timeout_latency: error %0d cycles after launch, required %0d",
                 err_cyc - tx_cycs[base_t], START_TIMEOUT + 1);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL timeout_busy: busy=%b required 0", bus.busy);
      end
    end
    n = 0;
    while (tx_bytes.size() < base_t + 2 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (tx_bytes.size() < base_t + 2 || tx_grants[base_t + 1] !== 3'd3) begin
      errors++;
      $display("FAIL timeout_next: next owner %0d required 3", tx_grants[tx_grants.size() - 1]);
    end
    wait_drain("timeout", 1000);
    checks++;
    if (lerr_cycs.size() - base_e != 1) begin
      errors++;
      $display("FAIL timeout_once: %0d error pulse cycles, required 1", lerr_cycs.size() - base_e);
    end
  endtask

  task automatic test_reset_mid_byte();
    int n;
    int snap;
    apply_reset();
    frame_len = 20;
    start_dly = 1;
    @(negedge clk);
    push_byte(2, 1'b1, 8'h3C);
    n = 0;
    while (!bus.uart_is_transmitting && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    push_byte(0, 1'b1, 8'h5D);
    apply_reset();
    snap = tx_bytes.size();
    n = 0;
    while (bus.uart_is_transmitting && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (tx_bytes.size() != snap) begin
      errors++;
      $display("FAIL rstmid_gate: %0d launches while uart busy, required 0", tx_bytes.size() - snap);
    end
    n = 0;
    while (tx_bytes.size() == snap && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (tx_bytes.size() == snap || tx_grants[snap] !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_first: first owner after reset %0d required 0", tx_grants[tx_grants.size() - 1]);
    end
    frame_len = 6;
    start_dly = 2;
    wait_drain("rstmid", 1000);
  endtask

  task automatic test_random();
    int base_t;
    int base_a;
    int npk;
    int len;
    int rr;
    int win;
    logic [8:0] mdl [N_REQ][DEPTH];
    int mlen [N_REQ];
    int mptr [N_REQ];
    logic [8:0] e;
    apply_reset();
    rand_timing = 1'b1;
    @(negedge clk);
    base_t = tx_bytes.size();
    base_a = ack_ids.size();
    exp_q.delete();
    exp_ack_q.delete();
    for (int i = 0; i < N_REQ; i++) begin
      mlen[i] = 0;
      mptr[i] = 0;
      npk = $urandom_range(0, 3);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          e = {(b == len - 1), 8'($urandom_range(0, 255))};
          mdl[i][mlen[i]] = e;
          mlen[i] = mlen[i] + 1;
          push_byte(i, e[8], e[7:0]);
        end
      end
    end
    // Reference: every requester with packets left is pending at each decision.
    rr = N_REQ - 1;
    forever begin
      win = -1;
      for (int k = 1; k <= N_REQ; k++) begin
        if (win < 0 && mptr[(rr + k) % N_REQ] < mlen[(rr + k) % N_REQ]) win = (rr + k) % N_REQ;
      end
      if (win < 0) break;
      if (HDR_EN == 1) exp_q.push_back(hdr_of(win));
      do begin
        e = mdl[win][mptr[win]];
        mptr[win] = mptr[win] + 1;
        exp_q.push_back(e[7:0]);
        exp_ack_q.push_back(win);
      end while (!e[8]);
      rr = win;
    end
    wait_drain("random", 5000);
    rand_timing = 1'b0;
    checks++;
    if (tx_bytes.size() - base_t != exp_q.size() || ack_ids.size() - base_a != exp_ack_q.size()) begin
      errors++;
      $display("FAIL random_count: %0d bytes %0d acks, required %0d/%0d",
               tx_bytes.size() - base_t, ack_ids.size() - base_a, exp_q.size(), exp_ack_q.size());
    end else begin
      foreach (exp_q[k]) begin
        checks++;
        if (tx_bytes[base_t + k] !== exp_q[k]) begin
          errors++;
          $display("FAIL random_byte[%0d]: got %h required %h", k, tx_bytes[base_t + k], exp_q[k]);
        end
      end
      foreach (exp_ack_q[k]) begin
        checks++;
        if (ack_ids[base_a + k] != exp_ack_q[k]) begin
          errors++;
          $display("FAIL random_ack[%0d]: got %0d required %0d", k, ack_ids[base_a + k], exp_ack_q[k]);
        end
      end
    end
  endtask

`ifdef UART_ARB_SRCID_EN
  task automatic test_srcid();
    int base_t;
    int base_a;
    apply_reset();
    @(negedge clk);
    base_t = tx_bytes.size();
    base_a = ack_ids.size();
    push_byte(3, 1'b1, 8'h41);
    wait_drain("srcid", 500);
    checks++;
    if (tx_bytes.size() - base_t != 2 || ack_ids.size() - base_a != 1) begin
      errors++;
      $display("FAIL srcid_count: %0d bytes %0d acks, required 2/1",
               tx_bytes.size() - base_t, ack_ids.size() - base_a);
    end else begin
      checks++;
      if (tx_bytes[base_t] !== 8'hA3 || tx_bytes[base_t + 1] !== 8'h41) begin
        errors++;
        $display("FAIL srcid_bytes: got %h %h required a3 41", tx_bytes[base_t], tx_bytes[base_t + 1]);
      end
      checks++;
      if (tx_acks[base_t] !== 4'b0000 || tx_acks[base_t + 1] !== 4'b1000) begin
        errors++;
        $display("FAIL srcid_ack: got %b %b required 0000 1000", tx_acks[base_t], tx_acks[base_t + 1]);
      end
    end
  endtask
`endif

  task automatic test_ack_rules();
    checks++;
    if (bad_acks != 0) begin
      errors++;
      $display("FAIL ack_rules: %0d acks off-owner or without launch, required 0", bad_acks);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_packet_lock();
    test_timeout();
    test_reset_mid_byte();
    test_random();
`ifdef UART_ARB_SRCID_EN
    test_srcid();
`endif
    test_ack_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
